// File: rtl/glb_bank_rd_streamer_if.sv
// Command, bank-port and output-stream signals of one global-buffer bank read streamer.
// master is the streamer side; slave is the surrounding DMA/bank side.
interface glb_bank_rd_streamer_if #(
    parameter int unsigned ADDR_W = 17,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LEN_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [LEN_W-1:0]  num_words;
    logic              busy;
    logic              done;
    logic              bank_ren;
    logic              bank_wen;
    logic [ADDR_W-1:0] bank_addr;
    logic [DATA_W-1:0] bank_data_out;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;

    modport master (
        input  start, start_addr, num_words, bank_data_out, out_ready,
        output busy, done, bank_ren, bank_wen, bank_addr, out_valid, out_data
    );

    modport slave (
        output start, start_addr, num_words, bank_data_out, out_ready,
        input  busy, done, bank_ren, bank_wen, bank_addr, out_valid, out_data
    );
endinterface

// File: rtl/glb_bank_rd_streamer.sv
// Bank read initiator: issues credit-limited reads, captures fixed-latency data
// into a small FIFO and presents it as a valid/ready stream.
module glb_bank_rd_streamer #(
    parameter int unsigned BANK_ADDR_WIDTH  = 17,
    parameter int unsigned BANK_DATA_WIDTH  = 64,
    parameter int unsigned BANK_BYTE_OFFSET = 3,
    parameter int unsigned RD_LATENCY       = 3,
    parameter int unsigned FIFO_DEPTH       = 8,
    parameter int unsigned LEN_WIDTH        = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    glb_bank_rd_streamer_if.master bus
);
    localparam int unsigned AW     = BANK_ADDR_WIDTH;
    localparam int unsigned DW     = BANK_DATA_WIDTH;
    localparam int unsigned LW     = LEN_WIDTH;
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned SUM_W  = CNT_W + 1;
    localparam int unsigned STRIDE = 2 ** BANK_BYTE_OFFSET;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [AW-1:0]         bank_addr_q, bank_addr_d;
    logic [LW-1:0]         remaining_q, remaining_d;
    logic                  bank_ren_q, bank_ren_d;
    logic                  done_q, done_d;
    logic [CNT_W-1:0]      inflight_q, inflight_d;
    logic [RD_LATENCY-1:0] vpipe_q, vpipe_d;

    logic [DW-1:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [CNT_W-1:0]      count_q;

    logic                  cmd_go;
    logic                  credit_ok;
    logic                  issue;
    logic [AW-1:0]         aligned_addr;
    logic [AW-1:0]         cur_addr;
    logic [LW-1:0]         cur_rem;
    logic                  push;
    logic                  pop;

    assign push = vpipe_q[RD_LATENCY-1];
    assign pop  = (count_q != '0) && bus.out_ready;

    // A read issued at the start edge shares the issue path with ISSUE so the
    // first bank_ren lands in the cycle right after start is sampled.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        bank_addr_d  = bank_addr_q;
        remaining_d  = remaining_q;
        bank_ren_d   = 1'b0;
        done_d       = 1'b0;
        aligned_addr = bus.start_addr & ~AW'(STRIDE - 1);
        cmd_go       = (state_q == IDLE) && bus.start;
        cur_addr     = cmd_go ? aligned_addr : addr_q;
        cur_rem      = cmd_go ? bus.num_words : remaining_q;
        credit_ok    = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(FIFO_DEPTH);
        issue        = (cmd_go || (state_q == ISSUE)) && (cur_rem != '0) && credit_ok;

        if (cmd_go) begin
            addr_d      = cur_addr;
            remaining_d = cur_rem;
        end
        if (issue) begin
            bank_ren_d  = 1'b1;
            bank_addr_d = cur_addr;
            addr_d      = cur_addr + AW'(STRIDE);
            remaining_d = cur_rem - LW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = ISSUE;
            end
            ISSUE: begin
                if (remaining_q == '0) state_d = DRAIN;
            end
            DRAIN: begin
                if ((inflight_q == '0) && (count_q == '0) && (vpipe_q == '0) && !bank_ren_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(push);
        vpipe_d    = vpipe_q << 1;
        vpipe_d[0] = bank_ren_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            bank_addr_q <= '0;
            remaining_q <= '0;
            bank_ren_q  <= 1'b0;
            done_q      <= 1'b0;
            inflight_q  <= '0;
            vpipe_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            bank_addr_q <= bank_addr_d;
            remaining_q <= remaining_d;
            bank_ren_q  <= bank_ren_d;
            done_q      <= done_d;
            inflight_q  <= inflight_d;
            vpipe_q     <= vpipe_d;
        end
    end

    // Response FIFO; storage is cleared so out_data reads zero after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= bus.bank_data_out;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop) rptr_q <= rptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.bank_ren  = bank_ren_q;
    assign bus.bank_wen  = 1'b0;
    assign bus.bank_addr = bank_addr_q;
    assign bus.out_valid = (count_q != '0);
    assign bus.out_data  = mem_q[rptr_q];
endmodule
